// File: rtl/outerprodrc_drain_if.sv
// Stream-side bundle of the accumulator drain: start/matrix in, clear pulse,
// element stream with indices, and busy/done status.
interface outerprodrc_drain_if #(
    parameter int ROWNUM      = 2,
    parameter int COLNUM      = 2,
    parameter int OUTBITWIDTH = 8
);
    localparam int RW = (ROWNUM > 1) ? $clog2(ROWNUM) : 1;
    localparam int CW = (COLNUM > 1) ? $clog2(COLNUM) : 1;

    logic                                  iStart;
    logic [ROWNUM*COLNUM*OUTBITWIDTH-1:0]  iData;
    logic                                  oClr;
    logic                                  oValid;
    logic                                  iReady;
    logic [OUTBITWIDTH-1:0]                oData;
    logic [RW-1:0]                         oRow;
    logic [CW-1:0]                         oCol;
    logic                                  oLast;
    logic                                  oBusy;
    logic                                  oDone;

    modport master (
        input  iStart, iData, iReady,
        output oClr, oValid, oData, oRow, oCol, oLast, oBusy, oDone
    );

    modport slave (
        output iStart, iData, iReady,
        input  oClr, oValid, oData, oRow, oCol, oLast, oBusy, oDone
    );
endinterface

// File: rtl/outerprodrc_drain.sv
// Snapshots the accumulator matrix on start, clears the array, then streams the
// snapshot out row-major over valid/ready.
module outerprodrc_drain #(
    parameter int ROWNUM      = 2,
    parameter int COLNUM      = 2,
    parameter int OUTBITWIDTH = 8
) (
    input  logic                 iClk,
    input  logic                 iRstN,
    outerprodrc_drain_if.master  bus
);
    localparam int RW = (ROWNUM > 1) ? $clog2(ROWNUM) : 1;
    localparam int CW = (COLNUM > 1) ? $clog2(COLNUM) : 1;
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWNUM - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLNUM - 1);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [OUTBITWIDTH-1:0] shadow [ROWNUM][COLNUM];
    logic [RW-1:0]          row;
    logic [CW-1:0]          col;
    logic                   clr;
    logic                   start_acc;
    logic                   hs;
    logic                   at_last;

    assign start_acc = (state == IDLE) && bus.iStart;
    assign hs        = (state == STREAM) && bus.iReady;
    assign at_last   = (row == ROW_MAX) && (col == COL_MAX);

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.iStart) state_next = STREAM;
            STREAM:  if (bus.iReady && at_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shadow copy decouples the stream from the array, which keeps accumulating.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            for (int r = 0; r < ROWNUM; r++)
                for (int c = 0; c < COLNUM; c++)
                    shadow[r][c] <= '0;
            row <= '0;
            col <= '0;
            clr <= 1'b0;
        end else begin
            clr <= start_acc;
            if (start_acc) begin
                for (int r = 0; r < ROWNUM; r++)
                    for (int c = 0; c < COLNUM; c++)
                        shadow[r][c] <= bus.iData[(r*COLNUM+c)*OUTBITWIDTH +: OUTBITWIDTH];
            end
            if (hs) begin
                if (col == COL_MAX) begin
                    col <= '0;
                    row <= (row == ROW_MAX) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_comb begin
        bus.oClr   = clr;
        bus.oValid = (state == STREAM);
        bus.oBusy  = (state == STREAM);
        bus.oDone  = (state == DONE);
        bus.oLast  = (state == STREAM) && at_last;
        bus.oRow   = row;
        bus.oCol   = col;
        bus.oData  = '0;
        if (state == STREAM) bus.oData = shadow[row][col];
    end
endmodule

// File: tb/tb_outerprodrc_drain.sv
// Directed table-driven bench for the 2x2 drain, plus reset sequences.
module tb_outerprodrc_drain;
    localparam logic [31:0] D1 = 32'h04030201;
    localparam logic [31:0] D2 = 32'h88776655;
    localparam logic [31:0] DF = 32'hFFFFFFFF;

    typedef struct {
        logic        clr, valid;
        logic [7:0]  odata;
        logic        row, col, last, busy, done;
        logic        start, ready;
        logic [31:0] data;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   hs_cnt;
    int   exp_hs;
    int   nv;
    vec_t vecs [64];

    outerprodrc_drain_if #(.ROWNUM(2), .COLNUM(2), .OUTBITWIDTH(8)) bus ();

    outerprodrc_drain #(.ROWNUM(2), .COLNUM(2), .OUTBITWIDTH(8)) dut (
        .iClk  (clk),
        .iRstN (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hs_cnt <= 0;
        else if (bus.oValid && bus.iReady) hs_cnt <= hs_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input logic clr, input logic valid,
                             input logic [7:0] d, input logic row, input logic col,
                             input logic last, input logic busy, input logic done);
        check({tag, ".oClr"},   32'(bus.oClr),   32'(clr));
        check({tag, ".oValid"}, 32'(bus.oValid), 32'(valid));
        check({tag, ".oData"},  32'(bus.oData),  32'(d));
        check({tag, ".oRow"},   32'(bus.oRow),   32'(row));
        check({tag, ".oCol"},   32'(bus.oCol),   32'(col));
        check({tag, ".oLast"},  32'(bus.oLast),  32'(last));
        check({tag, ".oBusy"},  32'(bus.oBusy),  32'(busy));
        check({tag, ".oDone"},  32'(bus.oDone),  32'(done));
    endtask

    task automatic add(input logic clr, input logic valid, input logic [7:0] d,
                       input logic row, input logic col, input logic last,
                       input logic busy, input logic done,
                       input logic start, input logic ready, input logic [31:0] data);
        vecs[nv] = '{clr, valid, d, row, col, last, busy, done, start, ready, data};
        nv++;
    endtask

    task automatic add_idle(input logic start, input logic ready, input logic [31:0] data);
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, start, ready, data);
    endtask

    task automatic add_el(input logic clr, input logic [7:0] d, input logic row,
                          input logic col, input logic last, input logic start,
                          input logic ready, input logic [31:0] data);
        add(clr, 1, d, row, col, last, 1, 0, start, ready, data);
    endtask

    task automatic add_done(input logic start, input logic ready, input logic [31:0] data);
        add(0, 0, 8'h00, 0, 0, 0, 0, 1, start, ready, data);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        nv     = 0;
        exp_hs = 0;
        rst_n      = 1'b0;
        bus.iStart = 1'b1;
        bus.iReady = 1'b0;
        bus.iData  = D1;

        // Reset held with start asserted and arbitrary ready
        for (int i = 0; i < 3; i++) begin
            bus.iReady = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check_out("rst_hold", 0, 0, 8'h00, 0, 0, 0, 0, 0);
        end
        bus.iStart = 1'b0;
        bus.iReady = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_out("rst_release", 0, 0, 8'h00, 0, 0, 0, 0, 0);
        end

        // Basic drain
        add_idle(1, 1, D1);
        add_el(1, 8'h01, 0, 0, 0, 0, 1, D1);
        add_el(0, 8'h02, 0, 1, 0, 0, 1, D1);
        add_el(0, 8'h03, 1, 0, 0, 0, 1, D1);
        add_el(0, 8'h04, 1, 1, 1, 0, 1, D1);
        add_done(0, 1, D1);
        // Backpressure at (0,1) and on the last element
        add_idle(1, 1, D1);
        add_el(1, 8'h01, 0, 0, 0, 0, 1, D1);
        add_el(0, 8'h02, 0, 1, 0, 0, 0, D1);
        add_el(0, 8'h02, 0, 1, 0, 0, 0, D1);
        add_el(0, 8'h02, 0, 1, 0, 0, 0, D1);
        add_el(0, 8'h02, 0, 1, 0, 0, 1, D1);
        add_el(0, 8'h03, 1, 0, 0, 0, 1, D1);
        add_el(0, 8'h04, 1, 1, 1, 0, 0, D1);
        add_el(0, 8'h04, 1, 1, 1, 0, 0, D1);
        add_el(0, 8'h04, 1, 1, 1, 0, 1, D1);
        add_done(0, 1, D1);
        // Snapshot isolation, start ignored in STREAM/DONE, restart right after done
        add_idle(1, 1, D1);
        add_el(1, 8'h01, 0, 0, 0, 1, 1, DF);
        add_el(0, 8'h02, 0, 1, 0, 0, 1, DF);
        add_el(0, 8'h03, 1, 0, 0, 0, 1, DF);
        add_el(0, 8'h04, 1, 1, 1, 1, 1, DF);
        add_done(1, 1, DF);
        add_idle(1, 1, D2);
        add_el(1, 8'h55, 0, 0, 0, 0, 1, D2);
        add_el(0, 8'h66, 0, 1, 0, 0, 1, D2);
        add_el(0, 8'h77, 1, 0, 0, 0, 1, D2);
        add_el(0, 8'h88, 1, 1, 1, 0, 1, D2);
        add_done(0, 1, D2);
        add_idle(0, 1, D2);

        for (int i = 0; i < nv; i++) begin
            check_out($sformatf("vec%0d", i), vecs[i].clr, vecs[i].valid, vecs[i].odata,
                      vecs[i].row, vecs[i].col, vecs[i].last, vecs[i].busy, vecs[i].done);
            if (vecs[i].valid && vecs[i].ready) exp_hs++;
            bus.iStart = vecs[i].start;
            bus.iReady = vecs[i].ready;
            bus.iData  = vecs[i].data;
            @(posedge clk); #1;
        end
        check("handshakes", 32'(hs_cnt), 32'(exp_hs));

        // Reset after the second handshake
        bus.iStart = 1'b1;
        bus.iReady = 1'b1;
        bus.iData  = D1;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
        check_out("mid_e0", 1, 1, 8'h01, 0, 0, 0, 1, 0);
        @(posedge clk); #1;
        check_out("mid_e1", 0, 1, 8'h02, 0, 1, 0, 1, 0);
        @(posedge clk); #1;
        check_out("mid_e2", 0, 1, 8'h03, 1, 0, 0, 1, 0);
        rst_n = 1'b0;
        #1;
        check_out("mid_rst", 0, 0, 8'h00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check_out("mid_rst_hold", 0, 0, 8'h00, 0, 0, 0, 0, 0);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_out("post_rst_idle", 0, 0, 8'h00, 0, 0, 0, 0, 0);
        bus.iStart = 1'b1;
        @(posedge clk); #1;
        bus.iStart = 1'b0;
        check_out("post_rst_e0", 1, 1, 8'h01, 0, 0, 0, 1, 0);
        @(posedge clk); #1;
        check_out("post_rst_e1", 0, 1, 8'h02, 0, 1, 0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/outerprodrc_drain.md
Name: outerprodrc_drain

Overview:
Readout engine for the outer-product accumulator array. The array produces a flat ROWNUM x COLNUM matrix of OUTBITWIDTH results. On a start pulse this block:
- snapshots the whole matrix into a shadow register;
- pulses a clear back to the array's iClr;
- streams the snapshot out one element per handshake, in row-major order, over a valid/ready interface.

The snapshot lets the array resume accumulating while the drain is still streaming.

Parameters:
ROWNUM, 2, number of array rows
COLNUM, 2, number of array columns
OUTBITWIDTH, 8, width of one accumulated result element

Ports:
iClk  input  1  clock, rising edge
iRstN  input  1  asynchronous active-low reset
iStart  input  1  request to snapshot and drain the matrix (sampled in IDLE only)
iData  input  ROWNUM*COLNUM*OUTBITWIDTH  flat matrix from array oData; element (r,c) at bits [(r*COLNUM+c)*OUTBITWIDTH +: OUTBITWIDTH]
oClr  output  1  one-cycle clear pulse to array iClr
oValid  output  1  oData/oRow/oCol/oLast valid
iReady  input  1  downstream accepts element when high with oValid
oData  output  OUTBITWIDTH  current element
oRow  output  max(1,$clog2(ROWNUM))  row index of current element
oCol  output  max(1,$clog2(COLNUM))  column index of current element
oLast  output  1  current element is (ROWNUM-1, COLNUM-1)
oBusy  output  1  high from snapshot until final handshake
oDone  output  1  one-cycle pulse after final handshake

Behaviour:
Reset (iRstN=0, asynchronous):
- state=IDLE; oClr, oValid, oLast, oBusy, oDone = 0.
- oData=0, oRow=0, oCol=0; shadow register cleared.

FSM states: IDLE, STREAM, DONE.

IDLE:
- iStart=1 at edge T:
  - shadow <= iData;
  - state <= STREAM; oClr=1 during cycle T+1 only;
  - oValid=1 from T+1 with element (0,0); oBusy=1 from T+1.
- iStart=0: stay IDLE; all outputs at reset values.

STREAM:
- Handshake = oValid && iReady at a rising edge.
- On handshake, advance to the next element:
  - if col < COLNUM-1: col++;
  - else col <= 0 and row++.
- oLast=1 exactly while (row,col) = (ROWNUM-1, COLNUM-1).
- Handshake while oLast=1: oValid <= 0, state <= DONE.
- Stall: while oValid=1 and iReady=0, oData/oRow/oCol/oLast are held stable. oValid never drops before its handshake.
- oData is always a shadow element, never live iData. Array changes after the snapshot do not affect the stream.
- iStart is ignored in STREAM.

DONE:
- oDone=1 for exactly one cycle; oBusy=0; oValid=0; row/col reset to 0.
- Next state is IDLE unconditionally; iStart is ignored in DONE.
- Minimum turnaround: a new iStart is accepted one cycle after oDone.

Timing and limits:
- With iReady held 1 and start at T: elements occupy cycles T+1 .. T+N, where N=ROWNUM*COLNUM; oDone at T+N+1.
- Throughput is one element per cycle, with no bubbles between elements.
- ROWNUM=COLNUM=1: element (0,0) is presented with oLast=1 immediately.

Reset mid-operation:
- Immediate return to reset values.
- No further oClr pulse and no oDone.
- The partially streamed snapshot is discarded.

Arithmetic: elements are passed through bit-exact, with no sign or width conversion. Index counters wrap only as specified and never exceed ROWNUM-1 / COLNUM-1.

Test Plan:
- Reset: hold iRstN=0 with iStart=1 and random iReady -> all outputs 0; release reset with iStart=0 -> outputs stay 0, state stays IDLE.
- Basic drain: 2x2, iData={8'h04,8'h03,8'h02,8'h01}, iStart pulse at T, iReady=1 ->
  - oClr=1 at T+1 only;
  - elements (0,0)=01, (0,1)=02, (1,0)=03, (1,1)=04 at T+1..T+4;
  - oLast only at T+4; oDone at T+5; oBusy high T+1..T+4.
- Backpressure: same data, iReady=0 for 3 cycles at element (0,1), and also during the oLast element -> oData stays 8'h02 and oLast stays 1 respectively while stalled; no element dropped or duplicated; exactly 4 handshakes.
- Snapshot isolation: change iData to all 8'hFF one cycle after start -> the stream still outputs 01,02,03,04.
- Start ignored while busy: pulse iStart during STREAM and during DONE -> no second oClr, order unchanged; a new iStart one cycle after oDone restarts at (0,0).
- Reset mid-stream: assert iRstN=0 after the second handshake -> outputs go to 0 immediately; no oDone; after release, a new iStart drains from (0,0).
